// File: rtl/cla_pipe_addsub_if.sv
// Handshake/bus bundle for cla_pipe_addsub.
// Both sides follow strict valid/ready semantics: a beat moves across a
// boundary on a rising edge exactly when its valid and ready are both 1.
// A producer may not make valid depend on ready, and the block holds its
// result stable while out_valid is 1 and out_ready is 0.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Arithmetic block side.
    modport slave (
        input  in_valid, a, b, sub, cin, sat, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, sub, cin, sat, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// WIDTH bits are split into STAGES segments of SEG = WIDTH/STAGES bits; each
// segment is resolved from 4-bit lookahead groups and its carry is registered
// into the next segment. Operands travel with the beat, finished sum bits are
// carried forward. Flow control is one global advance signal, no bubbles are
// collapsed. Optional signed saturation is compiled in with CLA_PIPE_SAT_EN.
module cla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NG   = SEG / 4;
    localparam int LAST = STAGES - 1;

    if ((WIDTH % 4) != 0 || (SEG % 4) != 0 || (SEG * STAGES) != WIDTH) begin : g_bad_cfg
        $error("cla_pipe_addsub: WIDTH and WIDTH/STAGES must be multiples of 4");
    end

    // One segment: returns {carry out, carry into segment MSB, sum bits}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] x,
                                               input logic [SEG-1:0] y,
                                               input logic           ci);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] s;
        logic [NG-1:0]  gp;
        logic [NG-1:0]  gg;
        logic [NG:0]    gc;
        logic [3:0]     bc;
        logic           term;
        p  = x ^ y;
        g  = x & y;
        s  = '0;
        bc = '0;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        // Group carries in flat lookahead form: any group generates and all later ones propagate.
        gc    = '0;
        gc[0] = ci;
        for (int j = 1; j <= NG; j++) begin
            term = ci;
            for (int t = 0; t < j; t++) term = term & gp[t];
            gc[j] = term;
            for (int m = 0; m < j; m++) begin
                term = gg[m];
                for (int t = m + 1; t < j; t++) term = term & gp[t];
                gc[j] = gc[j] | term;
            end
        end
        // Bit carries inside each 4-bit group.
        for (int j = 0; j < NG; j++) begin
            bc[0] = gc[j];
            bc[1] = g[4*j] | (p[4*j] & gc[j]);
            bc[2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            bc[3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
            s[4*j +: 4] = p[4*j +: 4] ^ bc;
        end
        return {gc[NG], bc[3], s};
    endfunction

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [SEG+1:0]   res_d [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_q;
`ifdef CLA_PIPE_SAT_EN
    logic [STAGES-1:0] sat_q;
`endif

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             advance;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_d;

    assign advance = ~out_valid_q | bus.out_ready;

    // Each stage resolves its own segment and merges it into the carried sum bits.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res_d[k] = seg_add(a_q[k][k*SEG +: SEG], b_q[k][k*SEG +: SEG], c_q[k]);
            s_d[k]   = s_q[k];
            s_d[k][k*SEG +: SEG] = res_d[k][SEG-1:0];
            c_d[k]   = res_d[k][SEG+1];
        end
    end

    // Final flags and optional clamp; ovf and cout always describe the raw result.
    always_comb begin
        ovf_d = res_d[LAST][SEG] ^ c_d[LAST];
        sum_d = s_d[LAST];
`ifdef CLA_PIPE_SAT_EN
        if (sat_q[LAST] && ovf_d) begin
            sum_d = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Pipeline shift: every stage and the output register move together on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            c_q         <= '0;
`ifdef CLA_PIPE_SAT_EN
            sat_q       <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            v_q[0] <= bus.in_valid;
            a_q[0] <= bus.a;
            b_q[0] <= bus.sub ? ~bus.b : bus.b;
            c_q[0] <= bus.cin ^ bus.sub;
            s_q[0] <= '0;
`ifdef CLA_PIPE_SAT_EN
            sat_q[0] <= bus.sat;
`endif
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                c_q[k] <= c_d[k-1];
                s_q[k] <= s_d[k-1];
`ifdef CLA_PIPE_SAT_EN
                sat_q[k] <= sat_q[k-1];
`endif
            end
            out_valid_q <= v_q[LAST];
            if (v_q[LAST]) begin
                sum_q  <= sum_d;
                cout_q <= c_d[LAST];
                ovf_q  <= ovf_d;
                zero_q <= ~|sum_d;
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: a 16-bit/4-stage instance with a scoreboard fed
// by an arithmetic model, plus a 32-bit/2-stage instance with directed beats.
module tb_cla_pipe_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;

    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(16)) if16 ();
    cla_pipe_addsub_if #(.WIDTH(32)) if32 ();

    cla_pipe_addsub #(.WIDTH(16), .STAGES(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    cla_pipe_addsub #(.WIDTH(32), .STAGES(2)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: unsigned for sum/carry, signed range for overflow.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin, input logic sat,
                                  output logic [31:0] s, output logic co, output logic ov,
                                  output logic z);
        longint full, half, ua, ub, sa, sb, t, r;
        full = longint'(1) << w;
        half = full >> 1;
        ua = longint'(a) & (full - 1);
        ub = longint'(b) & (full - 1);
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        if (sub) begin
            t  = ua - ub - longint'(cin);
            r  = sa - sb - longint'(cin);
            co = (t >= 0);
        end else begin
            t  = ua + ub + longint'(cin);
            r  = sa + sb + longint'(cin);
            co = (t >= full);
        end
        s  = 32'(t & (full - 1));
        ov = (r >= half) || (r < -half);
`ifdef CLA_PIPE_SAT_EN
        if (sat && ov) s = (ua >= half) ? 32'(half) : 32'(half - 1);
`else
        if (sat && 1'b0) s = 32'(0);
`endif
        z = (s == 32'd0);
    endfunction

    // Scoreboard for the 16-bit instance: {zero, ovf, cout, sum}.
    logic [18:0] exp_q[$];
    logic [18:0] held;
    logic        stall_prev = 1'b0;

    // Single compare process, evaluated at the falling edge where the bus is settled.
    always @(negedge clk) begin
        logic [31:0] ms;
        logic        mco, mov, mz;
        logic [18:0] act, exp;
        act = {if16.zero, if16.ovf, if16.cout, if16.sum};
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", {63'd0, if16.out_valid}, 64'd1);
                chk("stall_data_held", {45'd0, act}, {45'd0, held});
            end
            if (if16.out_valid && if16.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("result", {45'd0, act}, {45'd0, exp});
                end
                n_pop++;
            end
            stall_prev = if16.out_valid && !if16.out_ready;
            held = act;
            if (if16.in_valid && if16.in_ready) begin
                model(16, {16'd0, if16.a}, {16'd0, if16.b}, if16.sub, if16.cin, if16.sat,
                      ms, mco, mov, mz);
                exp_q.push_back({mz, mov, mco, ms[15:0]});
            end
        end
    end

    task automatic wait_idle16();
        int guard = 0;
        while ((exp_q.size() != 0 || if16.out_valid) && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("idle_bound", {63'd0, guard >= 60}, 64'd0);
    endtask

    // One isolated beat on the 16-bit instance with literal expectations and latency.
    task automatic beat16(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin, input logic sat,
                          input logic [15:0] e_sum, input logic e_co, input logic e_ov,
                          input logic e_z);
        int lat = 0;
        if16.out_ready = 1'b1;
        wait_idle16();
        if16.in_valid = 1'b1;
        if16.a = a; if16.b = b; if16.sub = sub; if16.cin = cin; if16.sat = sat;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        while (!if16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_sum"}, {48'd0, if16.sum}, {48'd0, e_sum});
        chk({name, "_cout"}, {63'd0, if16.cout}, {63'd0, e_co});
        chk({name, "_ovf"}, {63'd0, if16.ovf}, {63'd0, e_ov});
        chk({name, "_zero"}, {63'd0, if16.zero}, {63'd0, e_z});
    endtask

    // One isolated beat on the 32-bit/2-stage instance, against literals and the model.
    task automatic beat32(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] e_sum, input logic e_co,
                          input logic e_ov, input logic e_z);
        int lat = 0;
        logic [31:0] ms;
        logic mco, mov, mz;
        if32.in_valid = 1'b1;
        if32.a = a; if32.b = b; if32.sub = 1'b0; if32.cin = cin; if32.sat = 1'b0;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        while (!if32.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        model(32, a, b, 1'b0, cin, 1'b0, ms, mco, mov, mz);
        chk({name, "_latency"}, 64'(lat), 64'd2);
        chk({name, "_sum"}, {32'd0, if32.sum}, {32'd0, e_sum});
        chk({name, "_flags"}, {61'd0, if32.cout, if32.ovf, if32.zero}, {61'd0, e_co, e_ov, e_z});
        chk({name, "_model"}, {29'd0, if32.cout, if32.ovf, if32.zero, if32.sum},
            {29'd0, mco, mov, mz, ms});
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] ms;
        logic mco, mov, mz;
        int cnt, pops0;

        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.sub = 1'b0;
        if16.cin = 1'b0; if16.sat = 1'b0; if16.out_ready = 1'b1;
        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.sub = 1'b0;
        if32.cin = 1'b0; if32.sat = 1'b0; if32.out_ready = 1'b1;

        // Pin the model with hand-computed results.
        model(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0, ms, mco, mov, mz);
        chk("model_wrap", {31'd0, mz, mov, mco, ms}, {31'd0, 1'b1, 1'b0, 1'b1, 32'h0});
        model(16, 32'h0005, 32'h0007, 1'b1, 1'b1, 1'b0, ms, mco, mov, mz);
        chk("model_sub_borrow", {31'd0, mz, mov, mco, ms}, {31'd0, 1'b0, 1'b0, 1'b0, 32'hFFFD});
        model(32, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, ms, mco, mov, mz);
        chk("model_32_ovf", {31'd0, mz, mov, mco, ms}, {31'd0, 1'b1, 1'b1, 1'b1, 32'h0});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, if16.out_valid}, 64'd0);
        chk("rst_outputs", {45'd0, if16.zero, if16.ovf, if16.cout, if16.sum}, 64'd0);
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, if16.in_ready}, 64'd1);

        // Directed beats.
        beat16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_PIPE_SAT_EN
        beat16("sat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        beat16("sat_neg", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        beat16("sat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        beat16("sat_neg", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
        beat16("nosat_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        beat16("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        beat16("sub_5_7_b", 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b0);
        beat16("sub_eq", 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Back-to-back stream, then a 5-cycle stall with beats in flight.
        wait_idle16();
        pops0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            if16.in_valid = 1'b1;
            if16.a = 16'(i); if16.b = 16'(i * 16'h1111);
            if16.sub = 1'b0; if16.cin = 1'b0; if16.sat = 1'b0;
            @(posedge clk); #1;
            if (i >= 4) chk("stream_rate", {63'd0, if16.out_valid}, 64'd1);
        end
        if16.in_valid = 1'b0;
        if16.out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_in_ready", {63'd0, if16.in_ready}, 64'd0);
            chk("stall_sum", {48'd0, if16.sum}, 64'h3336);
        end
        if16.out_ready = 1'b1;
        wait_idle16();
        chk("stream_count", 64'(n_pop - pops0), 64'd8);

        // Reset with beats in flight.
        for (int i = 0; i < 5; i++) begin
            if16.in_valid = 1'b1;
            if16.a = pick16(); if16.b = pick16(); if16.sub = 1'($urandom);
            @(posedge clk); #1;
        end
        if16.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", {63'd0, if16.out_valid}, 64'd0);
        chk("midrst_outputs", {45'd0, if16.zero, if16.ovf, if16.cout, if16.sum}, 64'd0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (if16.out_valid) cnt++;
        end
        chk("midrst_no_stale", 64'(cnt), 64'd0);
        beat16("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

        // Random traffic with random back-pressure.
        repeat (400) begin
            if16.in_valid = ($urandom_range(0, 3) != 0);
            if16.a = pick16(); if16.b = pick16();
            if16.sub = 1'($urandom); if16.cin = 1'($urandom); if16.sat = 1'($urandom);
            if16.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        if16.in_valid = 1'b0;
        if16.out_ready = 1'b1;
        wait_idle16();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        // 32-bit, 2-stage instance: carries across the stage boundary.
        beat32("w32_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        beat32("w32_ovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
        beat32("w32_ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
